phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Controller that sequences a 2-bit phase datapath through phases 0→1→2→3. Each phase is held for a programmable dwell time, and the full pass repeats a programmable number of times. It sits in front of the phase-decode logic and drives its `state_i`. Completion and abort are reported to the requester through a start/busy/done handshake.

## Interface
- `CntW`, default 8: width of each per-phase dwell counter.
- `IterW`, default 4: width of the pass-repeat count.
- `clk_i` input 1: single clock, rising edge.
- `rst_ni` input 1: asynchronous active-low reset.
- `start_i` input 1: begin a sequence; sampled only in IDLE.
- `abort_i` input 1: terminate the sequence immediately.
- `dwell_i` input 4*CntW: dwell per phase.
  - Phase k uses bits `[k*CntW +: CntW]`.
  - Phase k is held for dwell+1 cycles.
- `iter_i` input IterW: extra passes; total passes = `iter_i`+1.
- `state_o` output 2: current phase, to the phase datapath.
- `busy_o` output 1: sequence in progress.
- `done_o` output 1: one-cycle pulse after normal completion.
- `aborted_o` output 1: one-cycle pulse after an abort.
- `pass_o` output IterW: index of the current pass, starting at 0.

## Operation
- **FSM states:** IDLE, RUN, FINISH. The FSM state is not visible on the ports.
- **Outputs are registered.** Reset values:
  - `state_o`=0, `busy_o`=0, `done_o`=0, `aborted_o`=0, `pass_o`=0.
  - Internal counters are 0 and the FSM is in IDLE.
- **IDLE:**
  - `start_i`=1 and `abort_i`=0: capture `dwell_i` and `iter_i` into shadow registers, then go to RUN with phase=0, dwell counter=0, pass=0.
  - `start_i` with `abort_i`=1 in the same cycle: stay in IDLE, no pulse.
  - `abort_i` alone in IDLE: ignored, no `aborted_o`.
- **RUN:**
  - Each cycle, if dwell counter == shadow dwell[phase], reset the counter to 0 and advance the phase; otherwise increment the counter.
  - Phase 3 → 0 wraps (2-bit wrap-around). On the wrap, if pass == shadow iter, go to FINISH; otherwise increment pass.
  - `start_i` is ignored in RUN.
  - Input changes to `dwell_i` and `iter_i` during RUN have no effect; only the shadow copies are used.
- **Abort:** `abort_i`=1 in RUN goes to IDLE next cycle and has priority over all phase/pass advance in that cycle. Next-cycle values:
  - `state_o`=0, `busy_o`=0, `pass_o`=0.
  - `aborted_o`=1 for one cycle, `done_o`=0.
- **FINISH:** lasts exactly one cycle. `done_o`=1, `busy_o`=0, `state_o`=0, `pass_o`=0. The next state is IDLE unconditionally.
  - `start_i` in FINISH is ignored.
  - `abort_i` in FINISH is ignored; `done_o` still pulses.
- **Counter widths:** the dwell counter is CntW bits and never exceeds the shadow dwell, so it cannot overflow. The pass counter is IterW bits with the same property.
- **`state_o` values:** always in 0..3. No illegal encodings exist, so downstream decode needs no default.
- **Reset mid-operation:** asynchronous. All outputs go to their reset values immediately; no `done_o` or `aborted_o` is generated.

## Timing
- `start_i` high at edge t (in IDLE):
  - From t+1: `busy_o`=1, `state_o`=0.
  - Phase k occupies dwell_k+1 consecutive cycles.
- One pass lasts P = Σ(dwell_k+1) cycles. `busy_o` is high for exactly (iter+1)·P cycles.
- `done_o` is high in the first cycle after the last RUN cycle, while `busy_o`=0.
- The earliest restart is `start_i` sampled in the cycle after FINISH. Back-to-back sequences therefore have a minimum 2-cycle gap of `busy_o` low (the FINISH cycle and the IDLE sample cycle).
- Minimum sequence (all dwell=0, iter=0): `state_o` shows 0,1,2,3 on four consecutive cycles, then `done_o` pulses.
- Abort latency is 1 cycle from the `abort_i` sample to `busy_o`=0.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_ni`=0 mid-RUN, asynchronously between edges.
  - Response: all outputs are 0 immediately, with no pulse. After release, IDLE holds until `start_i`.
- **Minimum sequence:**
  - Stimulus: dwell={0,0,0,0}, iter=0, start.
  - Response: `state_o`=0,1,2,3 on cycles t+1..t+4, `done_o` at t+5, `busy_o` high for 4 cycles.
- **Unequal dwells with repeat:**
  - Stimulus: dwell={2,0,1,3}, iter=1.
  - Response: per pass, `state_o` sequence 0,0,0,1,2,2,3,3,3,3 (P=10). Two passes, `pass_o` 0 then 1, `busy_o` high for 20 cycles, one `done_o`.
- **Shadow capture:**
  - Stimulus: start with dwell0=5, then change `dwell_i` to all-0 and `iter_i`=7 one cycle later.
  - Response: phase 0 still lasts 6 cycles and only one pass runs.
- **Abort:**
  - Stimulus: `abort_i` during phase 2 of pass 0.
  - Response: next cycle `aborted_o`=1, `busy_o`=0, `state_o`=0, `done_o` never asserted.
- **Simultaneous and ignored events:**
  - start+abort in IDLE → stays IDLE.
  - start during RUN → no restart; the phase sequence is unchanged.
  - abort in FINISH → `done_o`=1 and `aborted_o`=0.
  - Maximum dwell (255 for `CntW`=8) → the phase lasts 256 cycles with no wrap error.

Source files
------------

// File: rtl/phase_sequencer.sv
// Steps a 2-bit phase through 0..3, holding each phase for a programmable dwell,
// and repeats the pass iter+1 times with a start/busy/done/aborted handshake.
module phase_sequencer #(
  parameter int CntW  = 8,
  parameter int IterW = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [4*CntW-1:0]   dwell_i,
  input  logic [IterW-1:0]    iter_i,
  output logic [1:0]          state_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o,
  output logic [IterW-1:0]    pass_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]        fsm_q, fsm_d;
  logic [1:0]        phase_q, phase_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IterW-1:0]  pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [4*CntW-1:0] dwell_sh_q, dwell_sh_d;
  logic [IterW-1:0]  iter_sh_q, iter_sh_d;
  logic [CntW-1:0]   cur_dwell;

  always_comb begin
    case (phase_q)
      2'd0:    cur_dwell = dwell_sh_q[0*CntW +: CntW];
      2'd1:    cur_dwell = dwell_sh_q[1*CntW +: CntW];
      2'd2:    cur_dwell = dwell_sh_q[2*CntW +: CntW];
      default: cur_dwell = dwell_sh_q[3*CntW +: CntW];
    endcase
  end

  always_comb begin
    fsm_d      = fsm_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    dwell_sh_d = dwell_sh_q;
    iter_sh_d  = iter_sh_q;
    case (fsm_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          fsm_d      = S_RUN;
          dwell_sh_d = dwell_i;
          iter_sh_d  = iter_i;
          phase_d    = 2'd0;
          cnt_d      = '0;
          pass_d     = '0;
          busy_d     = 1'b1;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          fsm_d     = S_IDLE;
          phase_d   = 2'd0;
          cnt_d     = '0;
          pass_d    = '0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (cnt_q == cur_dwell) begin
          cnt_d   = '0;
          phase_d = phase_q + 2'd1;
          // Leaving phase 3 ends a pass; the last pass hands off to FINISH.
          if (phase_q == 2'd3) begin
            if (pass_q == iter_sh_q) begin
              fsm_d   = S_FINISH;
              phase_d = 2'd0;
              pass_d  = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              pass_d = pass_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        fsm_d = S_IDLE;
      end
      default: begin
        fsm_d   = S_IDLE;
        phase_d = 2'd0;
        cnt_d   = '0;
        pass_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q      <= S_IDLE;
      phase_q    <= 2'd0;
      cnt_q      <= '0;
      pass_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      dwell_sh_q <= '0;
      iter_sh_q  <= '0;
    end else begin
      fsm_q      <= fsm_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      dwell_sh_q <= dwell_sh_d;
      iter_sh_q  <= iter_sh_d;
    end
  end

  assign state_o   = phase_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign aborted_o = aborted_q;
  assign pass_o    = pass_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: a queue-based expected-output schedule checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_phase_sequencer;

  localparam int CntW  = 8;
  localparam int IterW = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [4*CntW-1:0] dwell_i = '0;
  logic [IterW-1:0]  iter_i = '0;
  logic [1:0]        state_o;
  logic              busy_o;
  logic              done_o;
  logic              aborted_o;
  logic [IterW-1:0]  pass_o;

  phase_sequencer #(.CntW(CntW), .IterW(IterW)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .dwell_i   (dwell_i),
    .iter_i    (iter_i),
    .state_o   (state_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .aborted_o (aborted_o),
    .pass_o    (pass_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]       st;
    logic             busy;
    logic             done;
    logic             ab;
    logic [IterW-1:0] pass;
  } exp_t;

  exp_t       cur;
  exp_t       sched[$];
  int         checks = 0;
  int         failures = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  int         ab_cnt = 0;
  int         pass1_cnt = 0;
  logic [1:0] trace[$];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: a start lays out the whole expected output schedule up front.
  initial begin
    exp_t e;
    int   d;
    cur = '0;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        sched.delete();
        cur = '0;
      end else if (cur.busy && abort_i) begin
        sched.delete();
        cur = '0;
        cur.ab = 1'b1;
      end else if (sched.size() == 0 && !cur.busy && !cur.done && start_i && !abort_i) begin
        for (int p = 0; p <= int'(iter_i); p++) begin
          for (int k = 0; k < 4; k++) begin
            d = int'(dwell_i[k*CntW +: CntW]);
            for (int c = 0; c <= d; c++) begin
              e = '0;
              e.st = 2'(k);
              e.busy = 1'b1;
              e.pass = IterW'(p);
              sched.push_back(e);
            end
          end
        end
        e = '0;
        e.done = 1'b1;
        sched.push_back(e);
        cur = sched.pop_front();
      end else if (sched.size() > 0) begin
        cur = sched.pop_front();
      end else begin
        cur = '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        chk("state_o", int'(state_o), int'(cur.st));
        chk("busy_o", int'(busy_o), int'(cur.busy));
        chk("done_o", int'(done_o), int'(cur.done));
        chk("aborted_o", int'(aborted_o), int'(cur.ab));
        chk("pass_o", int'(pass_o), int'(cur.pass));
        if (busy_o === 1'b1) begin
          busy_cnt++;
          trace.push_back(state_o);
          if (pass_o == 1) pass1_cnt++;
        end
        if (done_o === 1'b1) done_cnt++;
        if (aborted_o === 1'b1) ab_cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #2;
  endtask

  task automatic clear_stats();
    busy_cnt = 0;
    done_cnt = 0;
    ab_cnt = 0;
    pass1_cnt = 0;
    trace.delete();
  endtask

  task automatic kick(input logic [4*CntW-1:0] dw, input logic [IterW-1:0] it);
    dwell_i = dw;
    iter_i = it;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    int n;
    int zeros;
    int pat[10];
    pat = '{0, 0, 0, 1, 2, 2, 3, 3, 3, 3};

    repeat (3) tick();
    chk("reset_state", int'(state_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    chk("reset_aborted", int'(aborted_o), 0);
    chk("reset_pass", int'(pass_o), 0);
    rst_ni = 1'b1;
    repeat (3) tick();

    clear_stats();
    kick(32'h0, 4'd0);
    repeat (7) tick();
    chk("min_trace_len", trace.size(), 4);
    for (int i = 0; i < 4 && i < trace.size(); i++) chk("min_trace", int'(trace[i]), i);
    chk("min_busy", busy_cnt, 4);
    chk("min_done", done_cnt, 1);
    $display("test minimum_sequence busy=%0d done=%0d", busy_cnt, done_cnt);

    clear_stats();
    kick({8'd3, 8'd1, 8'd0, 8'd2}, 4'd1);
    repeat (5) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (25) tick();
    chk("rep_busy", busy_cnt, 20);
    chk("rep_done", done_cnt, 1);
    chk("rep_pass1", pass1_cnt, 10);
    chk("rep_trace_len", trace.size(), 20);
    for (int i = 0; i < 20 && i < trace.size(); i++) chk("rep_trace", int'(trace[i]), pat[i % 10]);
    $display("test unequal_dwell_repeat busy=%0d done=%0d", busy_cnt, done_cnt);

    clear_stats();
    kick(32'd5, 4'd0);
    dwell_i = '0;
    iter_i = 4'd7;
    repeat (15) tick();
    zeros = 0;
    foreach (trace[i]) if (trace[i] == 2'd0) zeros++;
    chk("shadow_phase0", zeros, 6);
    chk("shadow_busy", busy_cnt, 9);
    chk("shadow_done", done_cnt, 1);
    $display("test shadow_capture busy=%0d done=%0d", busy_cnt, done_cnt);

    clear_stats();
    kick(32'h01010101, 4'd2);
    for (n = 0; n < 40 && state_o != 2'd2; n++) tick();
    chk("abort_reach_phase2", int'(state_o), 2);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_pulse", int'(aborted_o), 1);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_state", int'(state_o), 0);
    chk("abort_pass", int'(pass_o), 0);
    repeat (10) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_count", ab_cnt, 1);
    $display("test abort aborted=%0d done=%0d", ab_cnt, done_cnt);

    clear_stats();
    dwell_i = '0;
    iter_i = '0;
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (3) tick();
    chk("start_abort_idle_busy", busy_cnt, 0);
    chk("start_abort_idle_ab", ab_cnt, 0);
    $display("test start_abort_idle busy=%0d", busy_cnt);

    clear_stats();
    kick(32'h0, 4'd0);
    for (n = 0; n < 20 && done_o !== 1'b1; n++) tick();
    chk("finish_reached", int'(done_o), 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    repeat (3) tick();
    chk("finish_abort_done", done_cnt, 1);
    chk("finish_abort_ab", ab_cnt, 0);
    $display("test abort_in_finish done=%0d aborted=%0d", done_cnt, ab_cnt);

    clear_stats();
    kick(32'd255, 4'd0);
    repeat (265) tick();
    chk("maxdwell_busy", busy_cnt, 259);
    chk("maxdwell_done", done_cnt, 1);
    $display("test max_dwell busy=%0d", busy_cnt);

    kick(32'h03030303, 4'd3);
    repeat (10) tick();
    #1 rst_ni = 1'b0;
    #1;
    chk("async_rst_state", int'(state_o), 0);
    chk("async_rst_busy", int'(busy_o), 0);
    chk("async_rst_done", int'(done_o), 0);
    chk("async_rst_aborted", int'(aborted_o), 0);
    chk("async_rst_pass", int'(pass_o), 0);
    clear_stats();
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (5) tick();
    chk("post_rst_idle", busy_cnt, 0);
    chk("post_rst_nopulse", done_cnt + ab_cnt, 0);
    $display("test async_reset busy=%0d", busy_cnt);

    clear_stats();
    for (int i = 0; i < 3000; i++) begin
      start_i = ($urandom % 6) == 0;
      abort_i = ($urandom % 50) == 0;
      for (int k = 0; k < 4; k++) dwell_i[k*CntW +: CntW] = CntW'($urandom % 4);
      iter_i = IterW'($urandom % 3);
      tick();
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (200) tick();
    $display("test random done=%0d aborted=%0d", done_cnt, ab_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
